cordic_arbiter: RTL
===================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one CORDIC core.
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the coordinate width (Q2.14).
REQ-003 The block SHALL have parameter ANGLE_WIDTH, default 32, giving the angle width (Q3.29 radians).
REQ-004 The block SHALL have parameter TIMEOUT, default 64, giving the maximum WAIT cycles before abort.
REQ-005 The block SHALL have parameter CORDIC_GAIN, default 16'h26DD, which is the x seed.
REQ-006 Port clock: input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 Port reset: input, 1 bit, asynchronous active-low reset.
REQ-008 Port req_valid: input, NUM_REQ bits, per-requester request valid.
REQ-009 Port req_ready: output, NUM_REQ bits, per-requester accept (one-hot or zero).
REQ-010 Port req_angle: input, NUM_REQ*ANGLE_WIDTH bits; requester i angle is bits [i*ANGLE_WIDTH +: ANGLE_WIDTH].
REQ-011 Port rsp_valid: output, 1 bit, result valid.
REQ-012 Port rsp_ready: input, 1 bit, result accepted.
REQ-013 Port rsp_id: output, clog2(NUM_REQ) bits, index of the requester that owns the result.
REQ-014 Ports rsp_cosine and rsp_sine: outputs, signed WIDTH bits each, the result.
REQ-015 Port rsp_timeout: output, 1 bit, the result is an abort rather than a computed value.
REQ-016 Port core_start: output, 1 bit, one-cycle start pulse to the CORDIC core.
REQ-017 Ports core_x_start and core_y_start: outputs, signed WIDTH bits each, the core seeds.
REQ-018 Port core_angle: output, signed ANGLE_WIDTH bits, the core angle.
REQ-019 Ports core_cosine and core_sine: inputs, signed WIDTH bits each, the core results.
REQ-020 Port core_done: input, 1 bit, core completion.
REQ-021 Port busy: output, 1 bit, high whenever state is not IDLE.
REQ-022 Port err_count: output, 8 bits, saturating timeout counter.

Function
REQ-023 The FSM SHALL have states IDLE, START, WAIT and RESP, with transitions IDLE->START->WAIT->RESP->IDLE.
REQ-024 In IDLE, req_ready SHALL be the combinational one-hot grant, and all-zero in every other state.
REQ-025 Round-robin priority SHALL run last_grant+1, last_grant+2, … wrapping to last_grant.
REQ-026 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; on transfer the block SHALL latch req_angle[i] and id i, then go to START.
REQ-027 In START, core_start SHALL be 1 for exactly one cycle.
REQ-028 core_angle SHALL hold the latched angle, unmodified, from START until leaving WAIT.
REQ-029 core_x_start SHALL be CORDIC_GAIN and core_y_start SHALL be 0 at all times out of reset.
REQ-030 core_done SHALL be sampled only in WAIT; a done in IDLE, START or RESP SHALL be ignored.
REQ-031 In WAIT, a 16-bit cycle counter SHALL be cleared on entry and increment every WAIT cycle.
REQ-032 In WAIT with core_done=1, the block SHALL register core_cosine/core_sine, set rsp_timeout=0, and go to RESP.
REQ-033 In WAIT with no done when the counter equals TIMEOUT-1, the block SHALL set cos/sin=0 and rsp_timeout=1, increment err_count (saturating at 255), and go to RESP.
REQ-034 core_done and the timeout condition in the same cycle SHALL resolve as done.
REQ-035 In RESP, rsp_valid SHALL be 1, and rsp_id/cosine/sine/timeout SHALL be stable until rsp_ready.
REQ-036 On rsp_valid and rsp_ready, the block SHALL set last_grant=rsp_id and go to IDLE; no new grant SHALL occur in that same cycle.
REQ-037 Latency: accept at cycle t gives core_start at t+1; done sampled at cycle d gives rsp_valid at d+1.
REQ-038 Throughput SHALL be one outstanding operation, with at least one IDLE cycle between operations.
REQ-039 A requester dropping req_valid before grant SHALL simply not be granted; no request is queued internally.

Reset
REQ-040 While reset=0, the state SHALL be IDLE and last_grant SHALL be NUM_REQ-1 (requester 0 first).
REQ-041 While reset=0, req_ready, rsp_valid, rsp_id, rsp_cosine, rsp_sine, rsp_timeout, core_start, core_angle, busy and err_count SHALL all be 0.
REQ-042 While reset=0, core_x_start SHALL be 0.
REQ-043 Reset asserted mid-operation SHALL abort the operation with no response; a core_done arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-044 Single request: req_valid[1] with angle 0 -> core_start 1 cycle after accept with core_angle=0; model done returns 0x4000/0x0000 -> rsp_id=1, cos=0x4000, sin=0, rsp_timeout=0.
REQ-045 Fairness: all four req_valid held high after reset -> grants in order 0,1,2,3,0,1; no requester is granted twice in a row.
REQ-046 Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_* stable, req_ready=0, no core_start; accept -> IDLE next cycle.
REQ-047 Hung core: core_done never asserted -> rsp_valid after 64 WAIT cycles with rsp_timeout=1 and cos=sin=0, err_count+1; 300 timeouts -> err_count=255.
REQ-048 Stray done: core_done pulsed during START and in IDLE -> ignored; the result comes only from a done in WAIT.
REQ-049 Mid-operation reset: reset low during WAIT -> outputs 0 immediately; after release, no response is emitted and requester 0 has highest priority.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that time-shares one CORDIC core among NUM_REQ requesters.
// It allows one operation in flight, aborts with a timeout result if the core hangs, and counts timeouts.
module cordic_arbiter #(
  parameter int                NUM_REQ     = 4,
  parameter int                WIDTH       = 16,
  parameter int                ANGLE_WIDTH = 32,
  parameter int                TIMEOUT     = 64,
  parameter logic [WIDTH-1:0]  CORDIC_GAIN = 16'h26DD,
  localparam int               ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ANGLE_WIDTH-1:0]   req_angle,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic signed [WIDTH-1:0]          rsp_cosine,
  output logic signed [WIDTH-1:0]          rsp_sine,
  output logic                             rsp_timeout,
  output logic                             core_start,
  output logic signed [WIDTH-1:0]          core_x_start,
  output logic signed [WIDTH-1:0]          core_y_start,
  output logic signed [ANGLE_WIDTH-1:0]    core_angle,
  input  logic signed [WIDTH-1:0]          core_cosine,
  input  logic signed [WIDTH-1:0]          core_sine,
  input  logic                             core_done,
  output logic                             busy,
  output logic [7:0]                       err_count
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic                    run_q;
  logic [ID_W-1:0]         last_grant;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W-1:0]         cand;
  logic [NUM_REQ-1:0]      grant;
  logic                    grant_any;
  logic [ANGLE_WIDTH-1:0]  angle_sel;
  logic [ANGLE_WIDTH-1:0]  angle_q;
  logic [15:0]             wait_cnt;
  logic                    accept;
  logic                    timeout_hit;

  // Search order starts just after the last owner, so last_grant itself is checked last.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(last_grant) + k) % unsigned'(NUM_REQ));
      if (!grant_any && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        grant_any   = 1'b1;
      end
    end
  end

  always_comb begin
    angle_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) angle_sel = req_angle[i*ANGLE_WIDTH +: ANGLE_WIDTH];
    end
  end

  // run_q holds off grants and the x seed until the first clock after reset release.
  assign accept      = (state == IDLE) && run_q && grant_any;
  assign timeout_hit = (state == WAIT) && !core_done && (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (run_q) req_ready = grant;
        if (accept) state_nx = START;
      end
      START: begin
        core_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (core_done || timeout_hit) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign core_angle   = ((state == START) || (state == WAIT)) ? angle_q : '0;
  assign core_x_start = run_q ? CORDIC_GAIN : '0;
  assign core_y_start = '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q       <= 1'b0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      angle_q     <= '0;
      rsp_id      <= '0;
      wait_cnt    <= '0;
      rsp_cosine  <= '0;
      rsp_sine    <= '0;
      rsp_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        angle_q <= angle_sel;
        rsp_id  <= grant_id;
      end
      if (state == START)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      // A done on the timeout cycle wins, so the done branch is checked first.
      if (state == WAIT) begin
        if (core_done) begin
          rsp_cosine  <= core_cosine;
          rsp_sine    <= core_sine;
          rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
          rsp_cosine  <= '0;
          rsp_sine    <= '0;
          rsp_timeout <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
      if ((state == RESP) && rsp_ready) last_grant <= rsp_id;
    end
  end

endmodule
